// File: rtl/ms6205_bus_sched.sv
// ms6205_bus_sched: arbiter and strobe sequencer for the MS6205 display latch bus.
// Console characters are queued in a small FIFO and written at a hardware cursor;
// the view scanner writes explicit cells. All state changes on the falling edge of Clk.
module ms6205_bus_sched #(
    parameter int unsigned SETUP_TICKS  = 1,
    parameter int unsigned STROBE_TICKS = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned COLUMNS      = 16,
    parameter int unsigned ROWS         = 10,
    parameter int unsigned CIO_BURST    = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       cio_valid,
    input  logic [7:0] cio_char,
    output logic       cio_ready,
    input  logic       cursor_clr,
    input  logic       scan_valid,
    input  logic [7:0] scan_addr,
    input  logic [7:0] scan_data,
    output logic       scan_ready,
    output logic [7:0] address,
    output logic [7:0] data_n,
    output logic       ms6205_addr_acq,
    output logic       ms6205_data_acq,
    output logic       busy,
    output logic [7:0] cursor
);

    localparam int unsigned MaxPos = COLUMNS * ROWS;
    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BurstW = $clog2(CIO_BURST + 1);

    // Counters are loaded with N-1 so a phase ends on the Tick that finds zero.
    localparam logic [2:0]        SetupLoad  = 3'(SETUP_TICKS - 1);
    localparam logic [2:0]        StrobeLoad = 3'(STROBE_TICKS - 1);
    localparam logic [CntW-1:0]   FifoFull   = CntW'(FIFO_DEPTH);
    localparam logic [BurstW-1:0] BurstMax   = BurstW'(CIO_BURST);
    localparam logic [7:0]        LastPos    = 8'(MaxPos - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddrSetup,
        StAddrStrobe,
        StDataSetup,
        StDataStrobe
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [7:0]        address_q, address_d;
    logic [7:0]        data_n_q, data_n_d;
    logic [7:0]        cursor_q, cursor_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              scan_ready_q;

    logic              fifo_empty, fifo_full, push, pop;
    logic [7:0]        head;
    logic              head_nl, idle_tick, cons_wins;
    logic              grant_cons, nl_pop, latch_cons, latch_scan;
    logic [7:0]        next_row, scan_cell;

    // Arbitration and grant decode; only evaluated into action when IDLE sees a Tick.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FifoFull);
        push       = cio_valid & ~fifo_full;
        head       = fifo_mem_q[rd_ptr_q];
        head_nl    = (head == 8'h0A);
        idle_tick  = Tick & (state_q == StIdle);
        // Arbitration comes first so a run of newlines cannot starve the scanner.
        cons_wins  = ~fifo_empty & ~((burst_q == BurstMax) & scan_valid);
        grant_cons = idle_tick & cons_wins;
        nl_pop     = grant_cons & head_nl;
        latch_cons = grant_cons & ~head_nl;
        latch_scan = idle_tick & ~cons_wins & scan_valid;
        pop        = grant_cons;
    end

    // FIFO pointer and occupancy update; a push while full is simply dropped.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Cursor row advance for newline, and out-of-range scanner cells folded to 0.
    always_comb begin
        if ((32'(cursor_q) / COLUMNS) + 1 >= ROWS) begin
            next_row = 8'h00;
        end else begin
            next_row = 8'(((32'(cursor_q) / COLUMNS) + 1) * COLUMNS);
        end
        scan_cell = (32'(scan_addr) >= MaxPos) ? 8'h00 : scan_addr;
    end

    // Bus latch, cursor and burst accounting for the upcoming edge.
    always_comb begin
        address_d = address_q;
        data_n_d  = data_n_q;
        cursor_d  = cursor_q;
        burst_d   = burst_q;
        if (latch_cons) begin
            address_d = cursor_q;
            data_n_d  = ~head;
            cursor_d  = (cursor_q == LastPos) ? 8'h00 : cursor_q + 8'd1;
        end else if (latch_scan) begin
            address_d = scan_cell;
            data_n_d  = ~scan_data;
        end else if (nl_pop) begin
            cursor_d = next_row;
        end
        // Clear overrides any advance; a concurrent write still used the old cursor.
        if (cursor_clr) begin
            cursor_d = 8'h00;
        end
        if (grant_cons) begin
            if (burst_q != BurstMax) begin
                burst_d = burst_q + BurstW'(1);
            end
        end else if (latch_scan || (idle_tick && fifo_empty)) begin
            burst_d = '0;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(negedge Clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cio_char;
        end
    end

    // Datapath and FIFO control registers.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            address_q    <= 8'h00;
            data_n_q     <= 8'hFF;
            cursor_q     <= 8'h00;
            burst_q      <= '0;
            scan_ready_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            address_q    <= address_d;
            data_n_q     <= data_n_d;
            cursor_q     <= cursor_d;
            burst_q      <= burst_d;
            scan_ready_q <= latch_scan;
        end
    end

    // FSM state and per-phase Tick counter.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: each phase counts down on Tick and exits when the count is zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (Tick) begin
            unique case (state_q)
                StIdle: begin
                    if (latch_cons || latch_scan) begin
                        state_d = StAddrSetup;
                        cnt_d   = SetupLoad;
                    end
                end
                StAddrSetup: begin
                    if (cnt_q == 3'd0) begin
                        state_d = StAddrStrobe;
                        cnt_d   = StrobeLoad;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StAddrStrobe: begin
                    if (cnt_q == 3'd0) begin
                        state_d = StDataSetup;
                        cnt_d   = SetupLoad;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StDataSetup: begin
                    if (cnt_q == 3'd0) begin
                        state_d = StDataStrobe;
                        cnt_d   = StrobeLoad;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StDataStrobe: begin
                    if (cnt_q == 3'd0) begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // FSM outputs: strobes decode straight from state so reset releases them at once.
    always_comb begin
        busy            = (state_q != StIdle);
        ms6205_addr_acq = (state_q != StAddrStrobe);
        ms6205_data_acq = (state_q != StDataStrobe);
    end

    assign cio_ready  = ~fifo_full;
    assign scan_ready = scan_ready_q;
    assign address    = address_q;
    assign data_n     = data_n_q;
    assign cursor     = cursor_q;

endmodule

// File: tb/tb_ms6205_bus_sched.sv
// Bench for ms6205_bus_sched: directed scenarios plus a randomized run, all checked
// against a transaction-level model (FIFO queue, integer cursor, Tick position).
module tb_ms6205_bus_sched;

    localparam int S     = 1;
    localparam int T     = 2;
    localparam int DEPTH = 4;
    localparam int COLS  = 16;
    localparam int ROWS  = 10;
    localparam int BURST = 4;
    localparam int MAXP  = COLS * ROWS;
    localparam int TXN   = 2 * (S + T);

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Tick = 1'b0;
    logic       cio_valid = 1'b0;
    logic [7:0] cio_char = 8'h00;
    logic       cursor_clr = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_addr = 8'h00;
    logic [7:0] scan_data = 8'h00;
    logic       cio_ready, scan_ready, addr_acq, data_acq, busy;
    logic [7:0] address, data_n, cursor;

    ms6205_bus_sched #(
        .SETUP_TICKS (S),
        .STROBE_TICKS(T),
        .FIFO_DEPTH  (DEPTH),
        .COLUMNS     (COLS),
        .ROWS        (ROWS),
        .CIO_BURST   (BURST)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Tick           (Tick),
        .cio_valid      (cio_valid),
        .cio_char       (cio_char),
        .cio_ready      (cio_ready),
        .cursor_clr     (cursor_clr),
        .scan_valid     (scan_valid),
        .scan_addr      (scan_addr),
        .scan_data      (scan_data),
        .scan_ready     (scan_ready),
        .address        (address),
        .data_n         (data_n),
        .ms6205_addr_acq(addr_acq),
        .ms6205_data_acq(data_acq),
        .busy           (busy),
        .cursor         (cursor)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state.
    logic [7:0]  mq[$];
    int          m_cursor;
    int          m_burst;
    int          m_p;        // Ticks since latch, -1 when idle
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    bit          m_srdy;
    logic [15:0] exp_wr[$];
    logic [15:0] obs_wr[$];

    // Bus writes as seen on the pins: captured when the data strobe falls.
    always @(negedge data_acq) begin
        if (Rst_n === 1'b1) obs_wr.push_back({address, ~data_n});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cursor = 0;
        m_burst  = 0;
        m_p      = -1;
        m_addr   = 8'h00;
        m_data   = 8'h00;
        m_srdy   = 1'b0;
    endtask

    // One falling edge of the spec's behaviour, using the inputs currently driven.
    task automatic model_edge();
        logic [7:0] c;
        bit         cons;
        bit         do_push;
        bit         srdy;
        int         cur_n;
        do_push = cio_valid && (mq.size() < DEPTH);
        srdy    = 1'b0;
        cur_n   = m_cursor;
        if (Tick) begin
            if (m_p >= 0) begin
                m_p++;
                if (m_p == 2 * S + T) exp_wr.push_back({m_addr, m_data});
                if (m_p == TXN) m_p = -1;
            end else begin
                cons = (mq.size() > 0) && !(m_burst == BURST && scan_valid);
                if (cons) begin
                    c = mq.pop_front();
                    m_burst = (m_burst < BURST) ? m_burst + 1 : BURST;
                    if (c == 8'h0A) begin
                        cur_n = ((m_cursor / COLS + 1) % ROWS) * COLS;
                    end else begin
                        m_addr = 8'(m_cursor);
                        m_data = c;
                        cur_n  = (m_cursor + 1) % MAXP;
                        m_p    = 0;
                    end
                end else if (scan_valid) begin
                    m_burst = 0;
                    m_addr  = (int'(scan_addr) < MAXP) ? scan_addr : 8'h00;
                    m_data  = scan_data;
                    m_p     = 0;
                    srdy    = 1'b1;
                end else begin
                    m_burst = 0;
                end
            end
        end
        if (cursor_clr) cur_n = 0;
        m_cursor = cur_n;
        if (do_push) mq.push_back(cio_char);
        m_srdy = srdy;
    endtask

    task automatic check_outputs();
        logic [7:0] inv;
        inv = ~m_data;
        chk("cio_ready", cio_ready, mq.size() < DEPTH);
        chk("busy", busy, m_p >= 0);
        chk("cursor", cursor, m_cursor);
        chk("scan_ready", scan_ready, m_srdy);
        chk("addr_acq", addr_acq, !(m_p >= S && m_p < S + T));
        chk("data_acq", data_acq, !(m_p >= 2 * S + T && m_p < TXN));
        chk("strobe_excl", addr_acq | data_acq, 1);
        if (m_p >= 0) begin
            chk("address", address, m_addr);
            chk("data_n", data_n, inv);
        end
    endtask

    // Called just after a rising edge; drives inputs, models the falling edge, checks.
    task automatic cyc(input bit tk, input bit cv, input logic [7:0] ch);
        Tick      = tk;
        cio_valid = cv;
        cio_char  = ch;
        @(negedge Clk);
        if (Rst_n) model_edge();
        else model_reset();
        @(posedge Clk);
        check_outputs();
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] ch);
        cyc(1'b0, 1'b1, ch);
    endtask

    task automatic send(input logic [7:0] ch);
        push(ch);
        tick();
        for (int i = 0; i < 20 && m_p >= 0; i++) tick();
        chk("send_idle", busy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (mq.size() > 0 || m_p >= 0); i++) tick();
        chk("drain_busy", busy, 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, obs_wr.size(), exp_wr.size());
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            chk(tag, obs_wr.pop_front(), exp_wr.pop_front());
        end
        obs_wr.delete();
        exp_wr.delete();
    endtask

    initial begin
        bit         tk;
        bit         cv;
        bit         will;
        logic [7:0] ch;
        int         fed;
        int         srdy_cnt;

        model_reset();
        Rst_n = 1'b0;
        @(posedge Clk);

        // Reset with Tick running.
        for (int i = 0; i < 4; i++) tick();
        chk("rst_addr_acq", addr_acq, 1);
        chk("rst_data_acq", data_acq, 1);
        chk("rst_data_n", data_n, 8'hFF);
        chk("rst_address", address, 8'h00);
        chk("rst_cursor", cursor, 8'h00);
        chk("rst_cio_ready", cio_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_scan_ready", scan_ready, 0);
        Rst_n = 1'b1;

        // Single console 'A': fixed Tick-by-Tick strobe timeline.
        push(8'h41);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk("A_addr_acq", addr_acq, !(k >= 2 && k <= 3));
            chk("A_data_acq", data_acq, !(k >= 5 && k <= 6));
            chk("A_busy", busy, k <= 6);
            if (k <= 6) begin
                chk("A_address", address, 8'h00);
                chk("A_data_n", data_n, 8'hBE);
            end
            cyc(1'b0, 1'b0, 8'h00);
        end
        chk("A_cursor", cursor, 8'd1);
        check_writes("A_bus");

        // FIFO fill: ready drops after four pushes; fifth waits for the first pop.
        for (int i = 0; i < 4; i++) begin
            chk("full_ready_hi", cio_ready, 1);
            push(8'(8'h61 + i));
        end
        chk("full_ready_lo", cio_ready, 0);
        cyc(1'b0, 1'b1, 8'h65);
        cyc(1'b0, 1'b1, 8'h65);
        chk("full_5th_held", cio_ready, 0);
        cyc(1'b1, 1'b1, 8'h65);
        chk("full_after_pop", cio_ready, 1);
        cyc(1'b0, 1'b1, 8'h65);
        chk("full_after_push", cio_ready, 0);
        drain();
        chk("full_cursor", cursor, 8'd6);
        chk("full_5th_write", (obs_wr.size() == 5) ? obs_wr[4] : 16'hFFFF, {8'd5, 8'h65});
        check_writes("full_bus");

        // Newline from cursor 37 moves to 48 without a bus cycle; 'B' lands at 48.
        cursor_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cursor_clr = 1'b0;
        chk("clr_cursor", cursor, 8'd0);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        chk("nl_pre", cursor, 8'd37);
        check_writes("nl_pre_bus");
        send(8'h0A);
        chk("nl_no_strobe", obs_wr.size(), 0);
        chk("nl_cursor", cursor, 8'd48);
        send(8'h42);
        chk("nl_B_write", (obs_wr.size() == 1) ? obs_wr[0] : 16'hFFFF, {8'd48, 8'h42});
        chk("nl_B_cursor", cursor, 8'd49);
        check_writes("nl_bus");

        // Cursor wrap at the last cell, and newline from the last row.
        cursor_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cursor_clr = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h0A);
        for (int i = 0; i < 15; i++) send(8'h2E);
        chk("wrap_pre", cursor, 8'd159);
        check_writes("wrap_pre_bus");
        send(8'h43);
        chk("wrap_write", (obs_wr.size() == 1) ? obs_wr[0] : 16'hFFFF, {8'd159, 8'h43});
        chk("wrap_cursor", cursor, 8'd0);
        check_writes("wrap_bus");
        for (int i = 0; i < 9; i++) send(8'h0A);
        for (int i = 0; i < 6; i++) send(8'h2D);
        chk("nl150_pre", cursor, 8'd150);
        send(8'h0A);
        chk("nl150_cursor", cursor, 8'd0);
        check_writes("nl150_bus");

        // Fairness: four console grants, then the waiting scanner, then console again.
        tick();
        for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
        scan_addr  = 8'd200;
        scan_data  = 8'h5A;
        scan_valid = 1'b1;
        fed        = 4;
        srdy_cnt   = 0;
        for (int n = 0; n < 600; n++) begin
            cv   = (fed < 6);
            will = cv && (mq.size() < DEPTH);
            cyc(n % 2 == 0, cv, 8'(8'h30 + fed));
            if (will) fed++;
            if (scan_ready === 1'b1) srdy_cnt++;
            if (m_srdy) scan_valid = 1'b0;
            if (fed == 6 && !scan_valid && mq.size() == 0 && m_p < 0) break;
        end
        chk("fair_done", busy, 0);
        chk("fair_srdy_width", srdy_cnt, 1);
        chk("fair_count", obs_wr.size(), 7);
        chk("fair_c4", (obs_wr.size() > 3) ? obs_wr[3] : 16'hFFFF, {8'd3, 8'h33});
        chk("fair_scan", (obs_wr.size() > 4) ? obs_wr[4] : 16'hFFFF, {8'd0, 8'h5A});
        chk("fair_c5", (obs_wr.size() > 5) ? obs_wr[5] : 16'hFFFF, {8'd4, 8'h34});
        check_writes("fair_bus");

        // Reset during the address strobe, with a full FIFO behind it.
        push(8'h51);
        tick();
        tick();
        for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
        chk("mid_addr_low", addr_acq, 0);
        chk("mid_full", cio_ready, 0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_addr_acq", addr_acq, 1);
        chk("mid_rst_data_acq", data_acq, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data_n", data_n, 8'hFF);
        chk("mid_rst_ready", cio_ready, 1);
        model_reset();
        obs_wr.delete();
        exp_wr.delete();
        @(posedge Clk);
        cyc(1'b1, 1'b0, 8'h00);
        Rst_n = 1'b1;
        tick();
        tick();
        chk("mid_fifo_discarded", busy, 0);
        chk("mid_no_write", obs_wr.size(), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tk = (n % 2 == 0) && ($urandom_range(3) != 0);
            cv = 1'($urandom_range(1));
            ch = ($urandom_range(7) == 0) ? 8'h0A : 8'($urandom_range(255));
            if (!scan_valid && $urandom_range(5) == 0) begin
                scan_valid = 1'b1;
                scan_addr  = 8'($urandom);
                scan_data  = 8'($urandom);
            end
            cursor_clr = ($urandom_range(40) == 0);
            cyc(tk, cv, ch);
            if (m_srdy) scan_valid = 1'b0;
        end
        cursor_clr = 1'b0;
        scan_valid = 1'b0;
        drain();
        check_writes("rand_bus");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
